// File: rtl/cim_op_scheduler_pkg.sv
// Shared definitions for the CIM operation scheduler: controller op codes,
// requester slot indices, FSM state encoding and a small modulo-3 helper.
// Ports: none (package).

package cim_op_scheduler_pkg;

   // Operation codes driven on r_w_cim towards the macro controller
   localparam logic [1:0] OP_IDLE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_CIM   = 2'b11;

   // Requester slots in the req/gnt/done vectors
   localparam logic [1:0] REQ_W = 2'd0;
   localparam logic [1:0] REQ_R = 2'd1;
   localparam logic [1:0] REQ_C = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_RUN       = 3'd3,
      S_DONE      = 3'd4
   } state_e;

   // Reduce a value in 0..5 to 0..2; used for round-robin index arithmetic
   function automatic logic [1:0] wrap3(input logic [2:0] v);
      logic [2:0] r;
      r = (v >= 3'd3) ? (v - 3'd3) : v;
      return r[1:0];
   endfunction

   // Requester slot k maps to op code k+1 (write/read/cim)
   function automatic logic [1:0] op_for_req(input logic [1:0] idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/cim_op_scheduler_rr_arbiter3.sv
// Purpose : combinational 3-way round-robin pick; first set req bit at or after ptr.
// Latency : purely combinational, no state.
// Backpress: none; the caller decides when the pick is consumed.
// Ports   : req_i (request vector), ptr_i (priority pointer 0..2),
//           vld_o (any request), gnt_o (one-hot pick), idx_o (picked slot).

module cim_op_scheduler_rr_arbiter3
   import cim_op_scheduler_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [1:0] ptr_i,
   output logic       vld_o,
   output logic [2:0] gnt_o,
   output logic [1:0] idx_o
);

   logic [1:0] cand;

   // Scan from the farthest offset down to the pointer so the closest
   // requester (lowest offset) is the one that survives.
   always_comb begin
      vld_o = 1'b0;
      gnt_o = 3'b000;
      idx_o = REQ_W;
      cand  = REQ_W;
      for (int i = 2; i >= 0; i--) begin
         cand = wrap3({1'b0, ptr_i} + 3'(i));
         if (req_i[cand]) begin
            vld_o = 1'b1;
            idx_o = cand;
            gnt_o = 3'b001 << cand;
         end
      end
   end

endmodule

// File: rtl/cim_op_scheduler.sv
// Purpose : arbitrates write/read/CIM requesters onto one DCIM macro controller,
//           running NPASS controller passes per CIM request.
// Latency : grant on the IDLE edge, start 1 cycle later, done 4 cycles after the
//           request is sampled when busy lasts one cycle.
// Backpress: controller busy stalls RUN; no grant while en is low; an op whose busy
//           never rises within TIMEOUT cycles is aborted with err.
// Ports   : clk, rst_b (async active-low), en, req[2:0] (write/read/cim),
//           gnt[2:0], done[2:0], err, pass_idx[2:0], r_w_cim[1:0], start, busy.

module cim_op_scheduler
   import cim_op_scheduler_pkg::*;
#(
   parameter int unsigned NPASS   = 2,
   parameter int unsigned TIMEOUT = 15
)(
   input  logic       clk,
   input  logic       rst_b,
   input  logic       en,
   input  logic [2:0] req,
   output logic [2:0] gnt,
   output logic [2:0] done,
   output logic       err,
   output logic [2:0] pass_idx,
   output logic [1:0] r_w_cim,
   output logic       start,
   input  logic       busy
);

   state_e     state_q,   state_d;
   logic [2:0] gnt_q,     gnt_d;
   logic [1:0] idx_q,     idx_d;
   logic [1:0] op_q,      op_d;
   logic [2:0] pass_q,    pass_d;
   logic [7:0] cnt_q,     cnt_d;
   logic       abort_q,   abort_d;
   logic [1:0] ptr_q,     ptr_d;

   logic       arb_vld;
   logic [2:0] arb_gnt;
   logic [1:0] arb_idx;

   cim_op_scheduler_rr_arbiter3 u_rr_arbiter3 (
      .req_i (req),
      .ptr_i (ptr_q),
      .vld_o (arb_vld),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         gnt_q   <= 3'b000;
         idx_q   <= REQ_W;
         op_q    <= OP_IDLE;
         pass_q  <= 3'd0;
         cnt_q   <= 8'd0;
         abort_q <= 1'b0;
         ptr_q   <= REQ_W;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         pass_q  <= pass_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      op_d    = op_q;
      pass_d  = pass_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      ptr_d   = ptr_q;

      case (state_q)
         S_IDLE: begin
            if (en && arb_vld) begin
               gnt_d   = arb_gnt;
               idx_d   = arb_idx;
               op_d    = op_for_req(arb_idx);
               pass_d  = 3'd0;
               abort_d = 1'b0;
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            // busy is deliberately not looked at here: a level still high
            // from the controller's previous activity must not count.
            cnt_d   = 8'd0;
            state_d = S_WAIT_BUSY;
         end

         S_WAIT_BUSY: begin
            if (busy) begin
               state_d = S_RUN;
            end else if (cnt_q == 8'(TIMEOUT)) begin
               // Abort ends the whole request, including any remaining CIM passes
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_RUN: begin
            if (!busy) begin
               if ((op_q == OP_CIM) && (pass_q < 3'(NPASS - 1))) begin
                  pass_d  = pass_q + 3'd1;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            ptr_d   = wrap3({1'b0, idx_q} + 3'd1);
            gnt_d   = 3'b000;
            op_d    = OP_IDLE;
            pass_d  = 3'd0;
            abort_d = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pulses decode straight from state so an async reset clears them at once
   assign start    = (state_q == S_ISSUE);
   assign done     = (state_q == S_DONE) ? gnt_q : 3'b000;
   assign err      = (state_q == S_DONE) && abort_q;
   assign gnt      = gnt_q;
   assign r_w_cim  = op_q;
   assign pass_idx = pass_q;

endmodule

// File: tb/tb_cim_op_scheduler.sv
// Directed bench for cim_op_scheduler (NPASS=2, TIMEOUT=15): reset, enable
// gating, round-robin rotation, single write, multi-pass CIM, timeout abort
// and reset in the middle of an operation.

module tb_cim_op_scheduler;

   logic       clk;
   logic       rst_b;
   logic       en;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [2:0] done;
   logic       err;
   logic [2:0] pass_idx;
   logic [1:0] r_w_cim;
   logic       start;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;
   int start_cnt = 0;

   cim_op_scheduler #(.NPASS(2), .TIMEOUT(15)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .en       (en),
      .req      (req),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .pass_idx (pass_idx),
      .r_w_cim  (r_w_cim),
      .start    (start),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start === 1'b1) start_cnt <= start_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serve one request from IDLE with a one-cycle busy per pass
   task automatic serve(input string tag, input logic [2:0] eg, input logic [1:0] eop,
                        input int np);
      int s0;
      s0 = start_cnt;
      tick();
      for (int p = 0; p < np; p++) begin
         chk({tag, "_gnt"},   32'(gnt), 32'(eg));
         chk({tag, "_op"},    32'(r_w_cim), 32'(eop));
         chk({tag, "_start"}, 32'(start), 32'd1);
         chk({tag, "_pass"},  32'(pass_idx), 32'(p));
         tick();
         chk({tag, "_start_low"}, 32'(start), 32'd0);
         busy = 1'b1;
         tick();
         busy = 1'b0;
         chk({tag, "_op_run"}, 32'(r_w_cim), 32'(eop));
         tick();
      end
      chk({tag, "_done"},     32'(done), 32'(eg));
      chk({tag, "_err"},      32'(err), 32'd0);
      chk({tag, "_gnt_done"}, 32'(gnt), 32'(eg));
      tick();
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      chk({tag, "_gnt_clr"},  32'(gnt), 32'd0);
      chk({tag, "_pass_clr"}, 32'(pass_idx), 32'd0);
      chk({tag, "_nstart"},   32'(start_cnt - s0), 32'(np));
   endtask

   initial begin
      int s0;
      int cyc;
      rst_b = 1'b0;
      en    = 1'b0;
      req   = 3'b000;
      busy  = 1'b0;
      tick();
      tick();
      chk("rst_gnt",   32'(gnt), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_pass",  32'(pass_idx), 32'd0);
      chk("rst_op",    32'(r_w_cim), 32'd0);
      rst_b = 1'b1;
      tick();

      // Enable gating: requests pending but no grant while en is low
      req = 3'b111;
      s0 = start_cnt;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("en_low_gnt", 32'(gnt), 32'd0);
      end
      chk("en_low_start", 32'(start_cnt - s0), 32'd0);

      // Round-robin rotation from pointer 0; first grant on the edge after en rises
      en = 1'b1;
      serve("rr0", 3'b001, 2'b01, 1);
      serve("rr1", 3'b010, 2'b10, 1);
      serve("rr2", 3'b100, 2'b11, 2);
      serve("rr3", 3'b001, 2'b01, 1);

      // Single write, busy high for 3 cycles, request dropped mid-operation
      req = 3'b001;
      s0 = start_cnt;
      tick();
      chk("wr_gnt",   32'(gnt), 32'b001);
      chk("wr_op",    32'(r_w_cim), 32'b01);
      chk("wr_start", 32'(start), 32'd1);
      req = 3'b000;
      tick();
      busy = 1'b1;
      tick();
      tick();
      tick();
      chk("wr_busy_nodone", 32'(done), 32'd0);
      busy = 1'b0;
      tick();
      chk("wr_done", 32'(done), 32'b001);
      chk("wr_err",  32'(err), 32'd0);
      tick();
      chk("wr_idle_gnt", 32'(gnt), 32'd0);
      chk("wr_idle_op",  32'(r_w_cim), 32'd0);
      chk("wr_nstart",   32'(start_cnt - s0), 32'd1);

      // Lone CIM request: two passes, single done
      req = 3'b100;
      serve("cim", 3'b100, 2'b11, 2);

      // Timeout on a read: busy never rises
      req = 3'b010;
      s0 = start_cnt;
      tick();
      chk("to_start", 32'(start), 32'd1);
      chk("to_gnt",   32'(gnt), 32'b010);
      req = 3'b000;
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done != 3'b000) begin
            cyc = i;
            break;
         end
      end
      chk("to_cycles", 32'(cyc), 32'd17);
      chk("to_done",   32'(done), 32'b010);
      chk("to_err",    32'(err), 32'd1);
      tick();
      chk("to_err_clr",  32'(err), 32'd0);
      chk("to_idle_gnt", 32'(gnt), 32'd0);
      chk("to_nstart",   32'(start_cnt - s0), 32'd1);

      // Pointer after read now favours CIM
      req = 3'b111;
      serve("to_next", 3'b100, 2'b11, 2);

      // Reset asserted while a read is in RUN with busy high
      req = 3'b010;
      tick();
      chk("mr_gnt_issue", 32'(gnt), 32'b010);
      tick();
      busy = 1'b1;
      tick();
      tick();
      chk("mr_gnt_run", 32'(gnt), 32'b010);
      #2;
      rst_b = 1'b0;
      #1;
      chk("mr_gnt",   32'(gnt), 32'd0);
      chk("mr_op",    32'(r_w_cim), 32'd0);
      chk("mr_done",  32'(done), 32'd0);
      chk("mr_start", 32'(start), 32'd0);
      chk("mr_pass",  32'(pass_idx), 32'd0);
      busy = 1'b0;
      tick();
      rst_b = 1'b1;
      req = 3'b111;
      serve("mr_after", 3'b001, 2'b01, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/cim_op_scheduler.md
Name: cim_op_scheduler

Overview:
- Arbitrates three requesters (write, read, CIM compute) for one DCIM macro controller.
- Sequences each granted operation onto the controller's r_w_cim/start/busy interface, then reports completion to the requester.
- A CIM request runs NPASS back-to-back controller passes, one per 4-bit input slice, so wider inputs are processed as consecutive 4-bit CIM operations.
- Sits between the host/command layer and the 4-bit-input controller of the 64x64 macro.

Parameters:
- NPASS, 2, controller passes per CIM request (1..8); pass_idx counts 0..NPASS-1.
- TIMEOUT, 15, max cycles from the start pulse to busy rising before the operation is aborted (1..255).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_b  input  1  asynchronous active-low reset.
- en  input  1  scheduler enable; when low, no new grant is issued.
- req  input  3  request vector: [0] write, [1] read, [2] CIM; level, sampled in IDLE only.
- gnt  output  3  one-hot grant, held from ISSUE through DONE.
- done  output  3  one-cycle completion pulse to the granted requester.
- err  output  1  one-cycle pulse, coincident with done, when the operation timed out.
- pass_idx  output  3  current CIM pass number; 0 outside CIM operations.
- r_w_cim  output  2  operation code to the controller; held stable for the whole operation.
- start  output  1  one-cycle start pulse to the controller.
- busy  input  1  controller busy.

Behaviour:
- Reset (rst_b low, asynchronous):
  - State is IDLE; gnt, done, err, start, pass_idx, r_w_cim and the timeout counter are all 0.
  - Round-robin pointer is 0 (write first).
- Op codes: IDLE=2'b00, WRITE=2'b01, READ=2'b10, CIM=2'b11.
- FSM states: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
- IDLE:
  - If en=1 and req!=0, select the first set req bit at or after the pointer, wrapping 0->1->2->0.
  - Load gnt and r_w_cim, and clear pass_idx, in the same edge.
  - Go to ISSUE.
- ISSUE:
  - start=1 for exactly this cycle; clear the timeout counter.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - busy=1 -> go to RUN.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to DONE with the abort flag set.
- RUN:
  - Wait while busy=1.
  - When busy=0: for CIM with pass_idx<NPASS-1, increment pass_idx and go to ISSUE. Otherwise go to DONE.
- DONE (one cycle):
  - done[k]=1 for the granted requester k; err=1 if aborted.
  - Pointer becomes (k+1) mod 3.
  - gnt, r_w_cim and pass_idx return to 0; go to IDLE.
- Latency: the start pulse follows the granting edge by exactly 1 cycle; no start pulses back-to-back. In an uncontended 1-cycle-busy case, done is asserted 4 cycles after req is sampled.
- A timeout on any CIM pass aborts the remaining passes; err is pulsed once.
- Requests dropped mid-operation are ignored; the operation completes.
- A new req seen in the DONE cycle is not granted until the next IDLE cycle. There is one idle cycle minimum between operations.
- en low mid-operation does not stop the current operation; it only blocks the next grant.
- busy=1 in IDLE, or already high in ISSUE, is ignored. busy is only examined in WAIT_BUSY and RUN.
- The pointer wraps 2->0. Unrequested slots are skipped without extra cycles.

Decomposition:
- Shared package holds:
  - op-code constants (IDLE/WRITE/READ/CIM);
  - requester index constants (REQ_W=0, REQ_R=1, REQ_C=2);
  - the FSM state enum.
- One natural sub-module, rr_arbiter3: combinational 3-way round-robin pick from req and pointer, producing a one-hot grant and an index.
- The FSM, counters and output registers stay in cim_op_scheduler.

Test Plan:
- Reset mid-RUN:
  - Stimulus: assert rst_b=0 while gnt=3'b010 and busy=1.
  - Response: all outputs 0 immediately; after release, the pointer serves write first.
- Single write:
  - Stimulus: req=3'b001 with busy high for 3 cycles after start.
  - Response: r_w_cim=2'b01, one start pulse, done=3'b001 one cycle after busy falls, err=0.
- All three requesting continuously:
  - Stimulus: req=3'b111 held.
  - Response: grants in order 001, 010, 100, 001; each followed by a done pulse.
- CIM with NPASS=2:
  - Stimulus: req=3'b100.
  - Response: two start pulses with pass_idx 0 then 1, r_w_cim=2'b11 throughout, a single done=3'b100.
- Timeout:
  - Stimulus: req=3'b010 with busy never rising, TIMEOUT=15.
  - Response: done=3'b010 and err=1 in the same cycle, 17 cycles after start; back to IDLE; the pointer then prefers CIM.
- Enable gating:
  - Stimulus: en=0 with req=3'b111.
  - Response: no grant and start stays 0. Raising en yields a grant on the next edge.
